// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Captures up to two retiring instructions per cycle (slot0 older) from the
// dual-issue commit stage. The trace-relevant ones are kept in program order
// in a first-word-fall-through FIFO and drained one per cycle over a
// valid/ready port. The block also keeps retire, cycle and branch-prediction
// counters.
module commit_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter bit TRACE_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_valid,
    input  logic [31:0] c0_pc,
    input  logic [3:0]  c0_wstrb,
    input  logic [4:0]  c0_dest,
    input  logic [31:0] c0_wdata,
    input  logic        c0_br_op,
    input  logic        c0_pred_ok,
    input  logic        c1_valid,
    input  logic [31:0] c1_pc,
    input  logic [3:0]  c1_wstrb,
    input  logic [4:0]  c1_dest,
    input  logic [31:0] c1_wdata,
    input  logic        c1_br_op,
    input  logic        c1_pred_ok,
    output logic        commit_stall,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_dest,
    output logic [31:0] trace_wdata,
    output logic [3:0]  trace_wstrb,
    output logic        overflow,
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count,
    output logic [31:0] br_count,
    output logic [31:0] br_hit
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Bytes whose strobe is clear carry no defined data; force them to zero.
    function automatic logic [31:0] mask_wdata(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

    logic [31:0]   r_pc    [DEPTH];
    logic [4:0]    r_dest  [DEPTH];
    logic [31:0]   r_wdata [DEPTH];
    logic [3:0]    r_wstrb [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_inst_count;
    logic [31:0]   r_cycle_count;
    logic [31:0]   r_br_count;
    logic [31:0]   r_br_hit;

    logic          w_q0;
    logic          w_q1;
    logic [CW-1:0] w_free;
    logic [1:0]    w_n_wr;
    logic          w_drop;
    logic          w_deq;
    logic [31:0]   w_first_pc;
    logic [4:0]    w_first_dest;
    logic [31:0]   w_first_wdata;
    logic [3:0]    w_first_wstrb;
    logic [AW-1:0] w_wr_ptr_p1;

    // Slot qualification, space check against the registered count, and write selection.
    always_comb begin
        w_q0   = c0_valid && (!TRACE_FILTER || ((c0_wstrb != 4'h0) && (c0_dest != 5'd0)));
        w_q1   = c1_valid && (!TRACE_FILTER || ((c1_wstrb != 4'h0) && (c1_dest != 5'd0)));
        w_free = CW'(DEPTH) - r_count;
        w_n_wr = 2'd0;
        w_drop = 1'b0;
        case ({w_q0, w_q1})
            2'b11: begin
                if (w_free >= CW'(2)) begin
                    w_n_wr = 2'd2;
                end else if (w_free == CW'(1)) begin
                    w_n_wr = 2'd1;
                    w_drop = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
            2'b10, 2'b01: begin
                if (w_free >= CW'(1)) begin
                    w_n_wr = 2'd1;
                end else begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_n_wr = 2'd0;
            end
        endcase
        w_deq = (r_count != CW'(0)) && trace_ready;
        // The older qualifying slot always lands at wr_ptr.
        if (w_q0) begin
            w_first_pc    = c0_pc;
            w_first_dest  = c0_dest;
            w_first_wdata = mask_wdata(c0_wdata, c0_wstrb);
            w_first_wstrb = c0_wstrb;
        end else begin
            w_first_pc    = c1_pc;
            w_first_dest  = c1_dest;
            w_first_wdata = mask_wdata(c1_wdata, c1_wstrb);
            w_first_wstrb = c1_wstrb;
        end
        w_wr_ptr_p1 = r_wr_ptr + AW'(1);
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_n_wr != 2'd0) begin
            r_pc[r_wr_ptr]    <= w_first_pc;
            r_dest[r_wr_ptr]  <= w_first_dest;
            r_wdata[r_wr_ptr] <= w_first_wdata;
            r_wstrb[r_wr_ptr] <= w_first_wstrb;
        end
        if (w_n_wr == 2'd2) begin
            r_pc[w_wr_ptr_p1]    <= c1_pc;
            r_dest[w_wr_ptr_p1]  <= c1_dest;
            r_wdata[w_wr_ptr_p1] <= mask_wdata(c1_wdata, c1_wstrb);
            r_wstrb[w_wr_ptr_p1] <= c1_wstrb;
        end
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_n_wr);
            r_rd_ptr   <= r_rd_ptr + AW'(w_deq);
            r_count    <= r_count + CW'(w_n_wr) - CW'(w_deq);
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Retire, cycle and branch-prediction counters (unfiltered, wrap at 2^32).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_count  <= 32'd0;
            r_cycle_count <= 32'd0;
            r_br_count    <= 32'd0;
            r_br_hit      <= 32'd0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            r_inst_count  <= r_inst_count + {31'd0, c0_valid} + {31'd0, c1_valid};
            r_br_count    <= r_br_count + {31'd0, c0_valid & c0_br_op}
                                        + {31'd0, c1_valid & c1_br_op};
            r_br_hit      <= r_br_hit + {31'd0, c0_valid & c0_br_op & c0_pred_ok}
                                      + {31'd0, c1_valid & c1_br_op & c1_pred_ok};
        end
    end

    assign commit_stall = (w_free < CW'(2));
    assign trace_valid  = (r_count != CW'(0));
    assign trace_pc     = trace_valid ? r_pc[r_rd_ptr]    : 32'h0;
    assign trace_dest   = trace_valid ? r_dest[r_rd_ptr]  : 5'd0;
    assign trace_wdata  = trace_valid ? r_wdata[r_rd_ptr] : 32'h0;
    assign trace_wstrb  = trace_valid ? r_wstrb[r_rd_ptr] : 4'h0;
    assign overflow     = r_overflow;
    assign inst_count   = r_inst_count;
    assign cycle_count  = r_cycle_count;
    assign br_count     = r_br_count;
    assign br_hit       = r_br_hit;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer (DEPTH=16, TRACE_FILTER=1).
module tb_commit_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_valid, c0_br_op, c0_pred_ok;
    logic [31:0] c0_pc, c0_wdata;
    logic [3:0]  c0_wstrb;
    logic [4:0]  c0_dest;
    logic        c1_valid, c1_br_op, c1_pred_ok;
    logic [31:0] c1_pc, c1_wdata;
    logic [3:0]  c1_wstrb;
    logic [4:0]  c1_dest;
    logic        commit_stall, trace_valid, trace_ready, overflow;
    logic [31:0] trace_pc, trace_wdata;
    logic [4:0]  trace_dest;
    logic [3:0]  trace_wstrb;
    logic [31:0] inst_count, cycle_count, br_count, br_hit;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ent_t;

    ent_t        sb[$];
    logic        m_ovf;
    logic [31:0] m_inst, m_cyc, m_br, m_hit;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .TRACE_FILTER(1'b1)) dut (
        .clk(clk), .reset(reset),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_wstrb(c0_wstrb), .c0_dest(c0_dest),
        .c0_wdata(c0_wdata), .c0_br_op(c0_br_op), .c0_pred_ok(c0_pred_ok),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_wstrb(c1_wstrb), .c1_dest(c1_dest),
        .c1_wdata(c1_wdata), .c1_br_op(c1_br_op), .c1_pred_ok(c1_pred_ok),
        .commit_stall(commit_stall), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_dest(trace_dest), .trace_wdata(trace_wdata),
        .trace_wstrb(trace_wstrb), .overflow(overflow), .inst_count(inst_count),
        .cycle_count(cycle_count), .br_count(br_count), .br_hit(br_hit)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        if (s[0]) m[7:0]   = d[7:0];
        if (s[1]) m[15:8]  = d[15:8];
        if (s[2]) m[23:16] = d[23:16];
        if (s[3]) m[31:24] = d[31:24];
        return m;
    endfunction

    task automatic slot(input int s, input logic v, input logic [31:0] pc, input logic [4:0] d,
                        input logic [31:0] wd, input logic [3:0] ws, input logic br,
                        input logic ok);
        if (s == 0) begin
            c0_valid = v; c0_pc = pc; c0_dest = d; c0_wdata = wd; c0_wstrb = ws;
            c0_br_op = br; c0_pred_ok = ok;
        end else begin
            c1_valid = v; c1_pc = pc; c1_dest = d; c1_wdata = wd; c1_wstrb = ws;
            c1_br_op = br; c1_pred_ok = ok;
        end
    endtask

    task automatic idle();
        slot(0, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
        slot(1, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_all();
        chk("trace_valid", trace_valid, sb.size() != 0);
        chk("commit_stall", commit_stall, (DEPTH - sb.size()) < 2);
        if (sb.size() != 0) begin
            chk("trace_pc", trace_pc, sb[0].pc);
            chk("trace_dest", trace_dest, sb[0].dest);
            chk("trace_wdata", trace_wdata, sb[0].wdata);
            chk("trace_wstrb", trace_wstrb, sb[0].wstrb);
        end
        chk("overflow", overflow, m_ovf);
        chk("inst_count", inst_count, m_inst);
        chk("cycle_count", cycle_count, m_cyc);
        chk("br_count", br_count, m_br);
        chk("br_hit", br_hit, m_hit);
    endtask

    // One clock: model the edge from the inputs currently driven, then check at negedge.
    task automatic tick();
        int   free_sp;
        logic q0, q1, deq;
        ent_t e0, e1;
        free_sp = DEPTH - sb.size();
        q0  = c0_valid && (c0_wstrb != 4'h0) && (c0_dest != 5'd0);
        q1  = c1_valid && (c1_wstrb != 4'h0) && (c1_dest != 5'd0);
        deq = trace_ready && (sb.size() != 0);
        e0  = '{pc: c0_pc, dest: c0_dest, wdata: exp_mask(c0_wdata, c0_wstrb), wstrb: c0_wstrb};
        e1  = '{pc: c1_pc, dest: c1_dest, wdata: exp_mask(c1_wdata, c1_wstrb), wstrb: c1_wstrb};
        @(posedge clk);
        if (reset) begin
            sb.delete();
            m_ovf = 1'b0; m_inst = 32'd0; m_cyc = 32'd0; m_br = 32'd0; m_hit = 32'd0;
        end else begin
            if (deq) void'(sb.pop_front());
            if (q0) begin
                if (free_sp > 0) begin sb.push_back(e0); free_sp--; end
                else m_ovf = 1'b1;
            end
            if (q1) begin
                if (free_sp > 0) begin sb.push_back(e1); free_sp--; end
                else m_ovf = 1'b1;
            end
            m_cyc  = m_cyc + 32'd1;
            m_inst = m_inst + 32'(c0_valid) + 32'(c1_valid);
            m_br   = m_br + 32'(c0_valid && c0_br_op) + 32'(c1_valid && c1_br_op);
            m_hit  = m_hit + 32'(c0_valid && c0_br_op && c0_pred_ok)
                           + 32'(c1_valid && c1_br_op && c1_pred_ok);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        m_ovf = 1'b0; m_inst = 32'd0; m_cyc = 32'd0; m_br = 32'd0; m_hit = 32'd0;
        trace_ready = 1'b1;
        do_reset();
        chk("rst_trace_pc", trace_pc, 32'h0);
        chk("rst_trace_wdata", trace_wdata, 32'h0);
        chk("rst_cycle", cycle_count, 32'd0);

        // 1: dual retire, drained in program order on consecutive cycles
        slot(0, 1'b1, 32'hbfc00000, 5'd2, 32'h11111111, 4'hf, 1'b0, 1'b0);
        slot(1, 1'b1, 32'hbfc00004, 5'd3, 32'h22222222, 4'hf, 1'b0, 1'b0);
        tick();
        chk("t1_head0", trace_pc, 32'hbfc00000);
        idle();
        tick();
        chk("t1_head1", trace_pc, 32'hbfc00004);
        tick();

        // 2: filtered slots are not traced but still counted as retired
        slot(0, 1'b1, 32'h100, 5'd0, 32'h5, 4'hf, 1'b0, 1'b0);
        slot(1, 1'b1, 32'h104, 5'd7, 32'h6, 4'h0, 1'b0, 1'b0);
        tick();
        chk("t2_no_enq", trace_valid, 1'b0);
        idle();
        tick();

        // 4: byte masking of write data
        slot(0, 1'b1, 32'h200, 5'd9, 32'hdeadbeef, 4'b0011, 1'b0, 1'b0);
        tick();
        chk("t4_wdata", trace_wdata, 32'h0000beef);
        chk("t4_wstrb", trace_wstrb, 4'h3);
        idle();
        tick();

        // 5: 40 single pushes with ready toggling, pointers wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            slot(0, 1'b1, 32'h1000 + 32'(i) * 32'd4, 5'(1 + (i % 31)), 32'(i) * 32'h01010101,
                 4'hf, 1'b0, 1'b0);
            trace_ready = i[0];
            tick();
            idle();
            trace_ready = 1'b1;
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        chk("t5_overflow", overflow, 1'b0);
        chk("t5_empty", trace_valid, 1'b0);

        // 3: fill with ready low; stall at 15, forced dual push stores one
        do_reset();
        trace_ready = 1'b0;
        slot(0, 1'b1, 32'h3000, 5'd1, 32'hcafe0000, 4'hf, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            slot(0, 1'b1, 32'h3004 + 32'(i) * 32'd8, 5'd4, 32'(i), 4'hf, 1'b0, 1'b0);
            slot(1, 1'b1, 32'h3008 + 32'(i) * 32'd8, 5'd5, 32'(i) + 32'd100, 4'hf, 1'b0, 1'b0);
            tick();
        end
        chk("t3_stall15", commit_stall, 1'b1);
        chk("t3_no_ovf_yet", overflow, 1'b0);
        slot(0, 1'b1, 32'h3100, 5'd6, 32'h77, 4'hf, 1'b0, 1'b0);
        slot(1, 1'b1, 32'h3104, 5'd6, 32'h88, 4'hf, 1'b0, 1'b0);
        tick();
        chk("t3_ovf", overflow, 1'b1);
        idle();
        trace_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();

        // 6: branch counters, then reset mid-run with data queued
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            slot(0, 1'b1, 32'h4000 + 32'(i) * 32'd8, 5'd1, 32'h1, 4'hf, 1'b1, 1'b1);
            slot(1, 1'b1, 32'h4004 + 32'(i) * 32'd8, 5'd2, 32'h2, 4'hf, 1'b1, 1'b0);
            tick();
        end
        chk("t6_br_count", br_count, 32'd6);
        chk("t6_br_hit", br_hit, 32'd3);
        idle();
        reset = 1'b1;
        tick();
        chk("t6_rst_valid", trace_valid, 1'b0);
        chk("t6_rst_br", br_count, 32'd0);
        chk("t6_rst_inst", inst_count, 32'd0);
        reset = 1'b0;

        // random traffic honouring commit_stall
        for (int i = 0; i < 400; i++) begin
            if ((DEPTH - sb.size()) < 2) begin
                idle();
            end else begin
                slot(0, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), $urandom,
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                slot(1, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), $urandom,
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            trace_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        trace_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
